// File: rtl/random_range_generator_if.sv
// Request/result bundle between the game-control FSM and the range generator.
// Master drives the request side; slave (the generator) returns the draw.
interface random_range_generator_if #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LFSR_WIDTH = 16
);
    logic                  i_request;
    logic [WIDTH-1:0]      i_max;
    logic                  i_seed_load;
    logic [LFSR_WIDTH-1:0] i_seed;
    logic                  o_busy;
    logic                  o_valid;
    logic [WIDTH-1:0]      o_value;
    logic                  o_fallback;

    modport master (
        output i_request, i_max, i_seed_load, i_seed,
        input  o_busy, o_valid, o_value, o_fallback
    );

    modport slave (
        input  i_request, i_max, i_seed_load, i_seed,
        output o_busy, o_valid, o_value, o_fallback
    );
endinterface

// File: rtl/random_range_generator.sv
// Uniform draw in 0..i_max from a free-running Galois LFSR, using rejection sampling
// with a bounded fallback so a draw never takes more than MAX_TRIES cycles.
module random_range_generator #(
    parameter int unsigned          WIDTH      = 4,
    parameter int unsigned          LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_WIDTH-1:0] SEED      = 16'hACE1,
    parameter int unsigned          MAX_TRIES  = 8
) (
    input logic                     i_clk,
    input logic                     i_rst_n,
    random_range_generator_if.slave bus
);
    localparam int unsigned TRIES_W = $clog2(MAX_TRIES) + 1;

    typedef enum logic [0:0] {StIdle, StDraw} state_e;

    state_e                state_q;
    logic                  req_q;
    logic [WIDTH-1:0]      max_q;
    logic [TRIES_W-1:0]    tries_q;
    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0]      mask;
    logic [WIDTH-1:0]      cand;
    logic [WIDTH:0]        fb_diff;
    logic                  rise;

    assign rise = bus.i_request & ~req_q;

    // Smallest all-ones mask covering max_q: bit i set if any bit at or above i is set.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            mask[i] = |(max_q >> i);
        end
    end

    assign cand    = lfsr_q[WIDTH-1:0] & mask;
    // cand <= 2*max_q+1, so this lands in 0..max_q whenever cand > max_q.
    assign fb_diff = {1'b0, cand} - ({1'b0, max_q} + {{WIDTH{1'b0}}, 1'b1});

    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        if (bus.i_seed_load) begin
            lfsr_d = (bus.i_seed == '0) ? SEED : bus.i_seed;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q <= SEED;
            req_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            req_q  <= bus.i_request;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= StIdle;
            max_q          <= '0;
            tries_q        <= '0;
            bus.o_busy     <= 1'b0;
            bus.o_valid    <= 1'b0;
            bus.o_value    <= '0;
            bus.o_fallback <= 1'b0;
        end else begin
            bus.o_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        max_q      <= bus.i_max;
                        tries_q    <= '0;
                        bus.o_busy <= 1'b1;
                        state_q    <= StDraw;
                    end
                end
                StDraw: begin
                    if (cand <= max_q) begin
                        bus.o_value    <= cand;
                        bus.o_fallback <= 1'b0;
                        bus.o_valid    <= 1'b1;
                        bus.o_busy     <= 1'b0;
                        state_q        <= StIdle;
                    end else if (tries_q == TRIES_W'(MAX_TRIES - 1)) begin
                        bus.o_value    <= fb_diff[WIDTH-1:0];
                        bus.o_fallback <= 1'b1;
                        bus.o_valid    <= 1'b1;
                        bus.o_busy     <= 1'b0;
                        state_q        <= StIdle;
                    end else begin
                        tries_q <= tries_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_random_range_generator.sv
// Directed bench for random_range_generator: a cycle-level reference model checked every
// cycle, plus literal expectations for reset, seed load, fallback and handshake corners.
module tb_random_range_generator;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    random_range_generator_if #(.WIDTH(4), .LFSR_WIDTH(16)) bus ();
    random_range_generator_if #(.WIDTH(4), .LFSR_WIDTH(16)) bf ();

    random_range_generator #(.WIDTH(4), .LFSR_WIDTH(16), .MAX_TRIES(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    random_range_generator #(.WIDTH(4), .LFSR_WIDTH(16), .MAX_TRIES(1)) dut_ft (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bf)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int mask_of(input int mx);
        int m = 0;
        while (m < mx) m = m * 2 + 1;
        return m;
    endfunction

    function automatic int cand_of(input logic [15:0] s, input int mx);
        return int'(s & 16'h000F) & mask_of(mx);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model for the main instance (8 tries).
    logic [15:0] m_lfsr;
    logic        m_req_q;
    logic        m_busy;
    int          m_max;
    int          m_tries;
    logic        m_valid;
    int          m_value;
    logic        m_fb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1; m_req_q <= 1'b0; m_busy <= 1'b0; m_max <= 0;
            m_tries <= 0; m_valid <= 1'b0; m_value <= 0; m_fb <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (!m_busy) begin
                if (bus.i_request && !m_req_q) begin
                    m_busy <= 1'b1; m_max <= int'(bus.i_max); m_tries <= 0;
                end
            end else if (cand_of(m_lfsr, m_max) <= m_max) begin
                m_busy <= 1'b0; m_valid <= 1'b1; m_value <= cand_of(m_lfsr, m_max); m_fb <= 1'b0;
            end else if (m_tries == 7) begin
                m_busy <= 1'b0; m_valid <= 1'b1; m_fb <= 1'b1;
                m_value <= cand_of(m_lfsr, m_max) - (m_max + 1);
            end else begin
                m_tries <= m_tries + 1;
            end
            if (bus.i_seed_load) m_lfsr <= (bus.i_seed == 16'h0) ? 16'hACE1 : bus.i_seed;
            else                 m_lfsr <= lfsr_step(m_lfsr);
            m_req_q <= bus.i_request;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.o_busy !== m_busy || bus.o_valid !== m_valid ||
                32'(bus.o_value) !== m_value || bus.o_fallback !== m_fb) begin
                failures++;
                $display("FAIL model_cmp t=%0t got busy=%b valid=%b value=%0d fb=%b expected busy=%b valid=%b value=%0d fb=%b",
                         $time, bus.o_busy, bus.o_valid, bus.o_value, bus.o_fallback,
                         m_busy, m_valid, m_value, m_fb);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    bit seen [16];
    int nvalid;
    int waited;

    initial begin
        bus.i_request = 1'b0; bus.i_max = '0; bus.i_seed_load = 1'b0; bus.i_seed = '0;
        bf.i_request  = 1'b0; bf.i_max  = '0; bf.i_seed_load  = 1'b0; bf.i_seed  = '0;

        // Model pinned to hand-computed steps.
        chk("step_ace1", 32'(lfsr_step(16'hACE1)), 32'hE270);
        chk("step_0001", 32'(lfsr_step(16'h0001)), 32'hB400);
        chk("mask_9", 32'(mask_of(9)), 32'd15);

        tick();
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_value", 32'(bus.o_value), 0);
        chk("rst_fallback", 32'(bus.o_fallback), 0);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        rst_n = 1'b1;
        tick();

        // i_max = 0: one DRAW cycle, value 0.
        bus.i_max = 4'd0; bus.i_request = 1'b1;
        tick();
        chk("max0_busy", 32'(bus.o_busy), 1);
        chk("max0_novalid", 32'(bus.o_valid), 0);
        bus.i_request = 1'b0;
        tick();
        chk("max0_valid", 32'(bus.o_valid), 1);
        chk("max0_value", 32'(bus.o_value), 0);
        chk("max0_fb", 32'(bus.o_fallback), 0);
        chk("max0_busy_clr", 32'(bus.o_busy), 0);
        tick();
        chk("max0_pulse", 32'(bus.o_valid), 0);

        // Full range: every draw accepted on the first DRAW cycle.
        bus.i_max = 4'd15;
        for (int d = 0; d < 100; d++) begin
            bus.i_request = 1'b1;
            tick();
            chk("full_busy", 32'(bus.o_busy), 1);
            bus.i_request = 1'b0;
            tick();
            chk("full_valid", 32'(bus.o_valid), 1);
        end

        // Seed load: zero maps to SEED, then 0x0001 steps to 0xB400.
        bus.i_seed_load = 1'b1; bus.i_seed = 16'h0000;
        tick();
        chk("seed0_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        bus.i_seed = 16'h0001;
        tick();
        chk("seed1_lfsr", 32'(dut.lfsr_q), 32'h0001);
        bus.i_seed_load = 1'b0;
        tick();
        chk("seed1_step", 32'(dut.lfsr_q), 32'hB400);

        // Fallback instance: lfsr nibble D at the draw edge, max 8 -> 13-9 = 4.
        bf.i_request = 1'b1; bf.i_seed_load = 1'b1; bf.i_seed = 16'h000D; bf.i_max = 4'd8;
        tick();
        chk("ft_busy", 32'(bf.o_busy), 1);
        bf.i_request = 1'b0; bf.i_seed_load = 1'b0;
        tick();
        chk("ft_valid", 32'(bf.o_valid), 1);
        chk("ft_value", 32'(bf.o_value), 4);
        chk("ft_fallback", 32'(bf.o_fallback), 1);
        chk("ft_busy_clr", 32'(bf.o_busy), 0);

        // Held request yields a single draw.
        nvalid = 0;
        bus.i_max = 4'd15; bus.i_request = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.o_valid) nvalid++;
        end
        bus.i_request = 1'b0;
        chk("held_one_valid", 32'(nvalid), 1);
        tick();

        // Two-cycle draw (nibbles F then 7, max 8); a rise during DRAW is ignored.
        bus.i_max = 4'd8; bus.i_request = 1'b1; bus.i_seed_load = 1'b1; bus.i_seed = 16'h000F;
        tick();
        chk("busy_rise_busy", 32'(bus.o_busy), 1);
        bus.i_request = 1'b0; bus.i_seed_load = 1'b0;
        tick();
        chk("busy_retry", 32'(bus.o_busy), 1);
        chk("busy_retry_nv", 32'(bus.o_valid), 0);
        bus.i_request = 1'b1;
        tick();
        chk("busy_done_valid", 32'(bus.o_valid), 1);
        chk("busy_done_value", 32'(bus.o_value), 7);
        nvalid = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.o_valid || bus.o_busy) nvalid++;
        end
        chk("busy_rise_ignored", 32'(nvalid), 0);
        bus.i_request = 1'b0;
        tick();

        // Asynchronous reset mid-draw.
        bus.i_max = 4'd8; bus.i_request = 1'b1; bus.i_seed_load = 1'b1; bus.i_seed = 16'h000F;
        @(posedge clk);
        #2;
        chk("arst_pre_busy", 32'(bus.o_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.o_busy), 0);
        chk("arst_valid", 32'(bus.o_valid), 0);
        chk("arst_value", 32'(bus.o_value), 0);
        chk("arst_fb", 32'(bus.o_fallback), 0);
        tick();
        bus.i_request = 1'b0; bus.i_seed_load = 1'b0;
        tick();
        rst_n = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.o_valid) nvalid++;
        end
        chk("arst_no_valid", 32'(nvalid), 0);

        // Many draws over 0..9, back to back.
        bus.i_max = 4'd9;
        for (int d = 0; d < 10000; d++) begin
            bus.i_request = 1'b1;
            tick();
            bus.i_request = 1'b0;
            waited = 0;
            while (!bus.o_valid && waited < 12) begin
                tick();
                waited++;
            end
            if (!bus.o_valid) begin
                chk("draw9_timeout", 32'(waited), 32'd0);
                break;
            end
            chk("draw9_range", 32'(bus.o_value <= 4'd9), 1);
            seen[bus.o_value] = 1'b1;
        end
        for (int v = 0; v < 10; v++) chk($sformatf("draw9_seen_%0d", v), 32'(seen[v]), 1);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/random_range_generator.md
# random_range_generator

Parametrised pseudo-random draw unit: a free-running Galois LFSR with a request/valid handshake that returns a uniformly distributed value in the inclusive range 0..i_max. Out-of-range candidates are rejected and redrawn, with a bounded fallback so latency never exceeds MAX_TRIES cycles. The block sits between the game-control FSM and the deck/card logic, and replaces the counter-sampling generator for card and suit draws.

## Interface
- WIDTH, 4: output/range width in bits; 1 ≤ WIDTH ≤ LFSR_WIDTH.
- LFSR_WIDTH, 16: LFSR state width.
- TAPS, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1: reset/fallback seed; must be nonzero.
- MAX_TRIES, 8: maximum rejection-sampling cycles per draw; must be ≥ 1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_request  in  1  draw request; a rising edge starts a draw.
- i_max  in  WIDTH  inclusive upper bound; sampled at draw start.
- i_seed_load  in  1  load i_seed into the LFSR on this edge.
- i_seed  in  LFSR_WIDTH  seed value.
- o_busy  out  1  draw in progress.
- o_valid  out  1  one-cycle pulse; o_value is new.
- o_value  out  WIDTH  last drawn value; held until the next o_valid.
- o_fallback  out  1  qualified by o_valid; high when the result came from the fallback path.

## Operation
- LFSR:
  - Advances every cycle, independent of state, so request timing adds entropy.
  - Galois step: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
  - i_seed_load has priority over the step. Loading i_seed == 0 loads SEED instead. The LFSR state is never zero.
- Request edge detect: req_q registers i_request; rise = i_request & ~req_q. req_q updates in every state.
- Mask: mask = smallest 2^k−1 ≥ max_q, computed combinationally from max_q (OR-smear of bits). max_q == 0 gives mask = 0.
- Candidate: cand = lfsr[WIDTH-1:0] & mask, taken from the current (pre-step) LFSR state.
- FSM, two states:
  - IDLE:
    - On rise: max_q <= i_max, tries <= 0, go to DRAW, o_busy <= 1.
    - Otherwise hold.
  - DRAW, evaluated every edge:
    - If cand ≤ max_q: o_value <= cand, o_fallback <= 0, o_valid <= 1, go to IDLE.
    - Else if tries == MAX_TRIES−1: o_value <= cand − (max_q+1), o_fallback <= 1, o_valid <= 1, go to IDLE.
    - Else tries <= tries+1 and stay.
    - Fallback arithmetic is done at WIDTH+1 bits. Because cand ≤ mask ≤ 2·max_q+1, the result is always in 0..max_q.
    - o_busy clears on the same edge o_valid asserts.
- tries counter width: $clog2(MAX_TRIES)+1.
- Rising edges of i_request while busy are ignored (not queued). A request held high does not retrigger.
- Seed load during DRAW: allowed. The draw continues using the new LFSR state from the next edge.
- Reset values: LFSR = SEED, state IDLE, req_q = 0, max_q = 0, tries = 0, o_busy = 0, o_valid = 0, o_value = 0, o_fallback = 0.
- Reset mid-draw: the draw is abandoned and no o_valid is produced.
- i_request high when reset releases counts as a rising edge at the first clock edge.

## Timing
- Edge k: i_request is first sampled high with req_q = 0; the block enters DRAW with o_busy = 1 after edge k.
- Best case: o_valid = 1 after edge k+1, so o_value is usable in the cycle following edge k+1.
- Worst case: o_valid after edge k+MAX_TRIES.
- o_valid is high for exactly one cycle. o_value and o_fallback change only on o_valid edges.
- Back-to-back throughput: a new rise can be accepted on the edge after o_valid. The minimum draw period is 2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then i_max = 0 with a request pulse at edge k → o_valid at edge k+1, o_value = 0, o_fallback = 0, o_busy high for exactly 1 cycle.
- WIDTH = 4, i_max = 15, 100 draws against a reference LFSR model from SEED 16'hACE1 → every draw completes in 1 DRAW cycle, and o_value equals the model's lfsr[3:0] at the draw edge.
- MAX_TRIES = 1, i_max = 8, seed chosen so lfsr[3:0] = 4'hD at the draw edge → o_value = 13−9 = 4 and o_fallback = 1.
- i_seed_load with i_seed = 0 → the LFSR holds 16'hACE1 next cycle. Loading 16'h0001 then stepping once gives 16'hB400.
- i_request held high for 20 cycles → exactly one o_valid. A second rising edge while o_busy is high → ignored.
- i_rst_n pulsed low while in DRAW → all outputs 0 immediately (asynchronously), no o_valid afterwards, and the next request works normally. Also: 10,000 draws with i_max = 9 → all results in 0..9 and every value seen.
